sample_packer: RTL and testbench
================================

# sample_packer

Parametrised successor of the single-frame sample-to-bus capture block, running entirely in the 50 MHz domain. A divider generates a sample-enable tick, and each tick captures one SAMPLE_W-bit sample into an assembly register. Every NUM_SAMPLES ticks the completed frame is handed to a valid/ready output register for the downstream window-function stage. Assembly continues while a frame waits for acceptance. A frame that cannot be handed off is dropped and flagged.

## Interface
Parameters:
- SAMPLE_W, 8, bits per sample (≥1)
- NUM_SAMPLES, 8, samples per frame (≥2)
- DIV, 1250, clk cycles per sample tick (≥2); 1250 gives 40 kHz at 50 MHz

Ports:
- Reset is asynchronous and active-low; one clock.
- clk_50mhz  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  sampling enable; low holds divider and frame index at 0
- sample_in  in  SAMPLE_W  sample, captured on tick edges
- ovf_clr  in  1  clears sticky overflow
- out  out  SAMPLE_W*NUM_SAMPLES  frame; sample k (k-th captured) in bits [k*SAMPLE_W +: SAMPLE_W]
- out_valid  out  1  frame on out is valid
- out_ready  in  1  downstream accepts frame when out_valid && out_ready
- overflow  out  1  sticky: at least one complete frame was dropped

## Operation
- Reset (async, rst_n=0): div_cnt=0, idx=0, assembly=0, out=0, out_valid=0, overflow=0.
- Divider:
  - div_cnt counts 0..DIV-1 while enable=1 and wraps to 0.
  - Width is $clog2(DIV).
  - tick = enable && (div_cnt==DIV-1).
- Capture: on a tick edge, assembly slot idx ← sample_in, and idx increments modulo NUM_SAMPLES.
- Frame complete is a tick with idx==NUM_SAMPLES-1. The full frame is the assembly register with the last slot replaced by sample_in, formed combinationally and loaded directly.
- Handoff on frame complete:
  - If out_valid==0, or out_valid && out_ready in the same cycle: out ← frame and out_valid ← 1.
  - Otherwise out and out_valid are unchanged, the frame is dropped, and overflow ← 1.
- Acceptance: out_valid && out_ready with no frame complete → out_valid ← 0. out retains its last value.
- Stability: out is stable while out_valid=1 and not accepted.
- enable=0:
  - div_cnt ← 0 and idx ← 0, so any partial frame is discarded.
  - The output register and handshake are unaffected; a pending frame still waits for out_ready.
- overflow:
  - ovf_clr=1 clears it.
  - A drop in the same cycle as ovf_clr wins, so overflow=1.
- Reset mid-frame or mid-handshake: everything returns to reset values immediately. The pending frame is lost and no overflow is flagged.

## Timing
- Sample k of a frame is taken at the rising edge ending the cycle where tick=1. With enable rising at cycle 0, tick falls in cycles DIV-1, 2*DIV-1, …
- out_valid rises at the same edge that captures the final sample. Latency from the final sample to out_valid is 0 additional cycles.
- Frame period is DIV*NUM_SAMPLES cycles.
- out_valid falls at the edge following the first cycle with out_ready=1, unless a new frame loads at that edge.
- out_ready may be held high permanently; every frame is then delivered and overflow never sets.
- No combinational path from out_ready to out_valid or out.

## Test plan
- Basic frame (DIV=4, NUM_SAMPLES=4, SAMPLE_W=8, out_ready=1): drive sample_in=0x11,0x22,0x33,0x44 at ticks → out=0x44332211, out_valid=1 for one cycle at the 4th tick edge (cycle 16 from enable), overflow=0.
- Backpressure: out_ready=0 after frame 1 (0x44332211); frame 2 completes → out holds 0x44332211 and overflow=1. Then out_ready=1 → accepted, out_valid=0 the next cycle. Frame 3 then loads normally.
- Simultaneous accept and complete: frame 1 pending with out_ready asserted exactly in frame 2's completion cycle → out=frame 2 and out_valid stays 1 with no gap. overflow=0.
- Enable drop mid-frame: deassert enable after 2 ticks, re-enable → first frame after re-enable contains only post-enable samples (slot 0 = first new sample), out_valid timing restarts at 4*DIV cycles.
- Async reset mid-handshake: rst_n=0 while out_valid=1 and overflow=1, asynchronously between edges → out=0, out_valid=0, overflow=0 immediately. Operation resumes from div_cnt=0 after release.
- ovf_clr vs drop: assert ovf_clr in the same cycle as a dropped frame → overflow=1. Assert ovf_clr alone the next cycle → overflow=0.

Source files
------------

// File: rtl/sample_packer.sv
// Packs NUM_SAMPLES divider-paced samples into one frame and offers it on a
// valid/ready output register; frames that find the register occupied are dropped.
module sample_packer #(
   parameter int SAMPLE_W    = 8,
   parameter int NUM_SAMPLES = 8,
   parameter int DIV         = 1250
) (
   input  logic                            clk_50mhz,
   input  logic                            rst_n,
   input  logic                            enable,
   input  logic [SAMPLE_W-1:0]             sample_in,
   input  logic                            ovf_clr,
   output logic [SAMPLE_W*NUM_SAMPLES-1:0] out,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            overflow
);

   localparam int DIV_W   = $clog2(DIV);
   localparam int IDX_W   = $clog2(NUM_SAMPLES);
   localparam int FRAME_W = SAMPLE_W * NUM_SAMPLES;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMPLES - 1);

   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [FRAME_W-1:0] asm_q, asm_d;
   logic [FRAME_W-1:0] out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic               overflow_q, overflow_d;

   logic               tick;
   logic               frame_done;
   logic               drop;
   logic [FRAME_W-1:0] frame;

   assign tick       = enable && (div_cnt_q == DIV_LAST);
   assign frame_done = tick && (idx_q == IDX_LAST);
   // The last sample bypasses the assembly register so the frame loads on its own tick edge.
   assign frame      = {sample_in, asm_q[FRAME_W-SAMPLE_W-1:0]};

   always_comb begin
      div_cnt_d = div_cnt_q;
      idx_d     = idx_q;
      asm_d     = asm_q;

      if (!enable) begin
         div_cnt_d = '0;
         idx_d     = '0;
      end else begin
         div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
         if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end
      end

      for (int k = 0; k < NUM_SAMPLES; k++) begin
         if (tick && (idx_q == IDX_W'(k))) begin
            asm_d[k*SAMPLE_W +: SAMPLE_W] = sample_in;
         end
      end
   end

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      drop        = 1'b0;

      if (frame_done) begin
         // An acceptance in the completion cycle frees the register for the new frame.
         if (!out_valid_q || out_ready) begin
            out_d       = frame;
            out_valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         idx_q       <= '0;
         asm_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer with DIV=4, NUM_SAMPLES=4, SAMPLE_W=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sample_packer;

   localparam int SAMPLE_W    = 8;
   localparam int NUM_SAMPLES = 4;
   localparam int DIV         = 4;

   logic                            clk_50mhz = 1'b0;
   logic                            rst_n     = 1'b0;
   logic                            enable    = 1'b0;
   logic [SAMPLE_W-1:0]             sample_in = '0;
   logic                            ovf_clr   = 1'b0;
   logic [SAMPLE_W*NUM_SAMPLES-1:0] out;
   logic                            out_valid;
   logic                            out_ready = 1'b0;
   logic                            overflow;

   int n_tests = 0;
   int n_fail  = 0;

   sample_packer #(
      .SAMPLE_W   (SAMPLE_W),
      .NUM_SAMPLES(NUM_SAMPLES),
      .DIV        (DIV)
   ) dut (
      .clk_50mhz(clk_50mhz),
      .rst_n    (rst_n),
      .enable   (enable),
      .sample_in(sample_in),
      .ovf_clr  (ovf_clr),
      .out      (out),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overflow (overflow)
   );

   always #5 clk_50mhz = ~clk_50mhz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Holds one sample for a full divider period, so exactly one tick captures it.
   task automatic win(input logic [7:0] v);
      sample_in = v;
      repeat (DIV) @(negedge clk_50mhz);
   endtask

   initial begin
      // Reset state
      @(negedge clk_50mhz);
      check("rst_out", out, 32'h0);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_ovf", {31'b0, overflow}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk_50mhz);

      // Basic frame with out_ready held high
      out_ready = 1'b1;
      enable    = 1'b1;
      win(8'h11); win(8'h22); win(8'h33);
      check("basic_pre_valid", {31'b0, out_valid}, 32'd0);
      win(8'h44);
      check("basic_out", out, 32'h44332211);
      check("basic_valid", {31'b0, out_valid}, 32'd1);
      check("basic_ovf", {31'b0, overflow}, 32'd0);
      enable = 1'b0;
      @(negedge clk_50mhz);
      check("basic_accept_valid", {31'b0, out_valid}, 32'd0);
      check("basic_retain_out", out, 32'h44332211);

      // Backpressure: second frame dropped while first waits
      out_ready = 1'b0;
      enable    = 1'b1;
      win(8'h01); win(8'h02); win(8'h03); win(8'h04);
      check("bp_f1_out", out, 32'h04030201);
      check("bp_f1_valid", {31'b0, out_valid}, 32'd1);
      win(8'h05); win(8'h06); win(8'h07); win(8'h08);
      check("bp_hold_out", out, 32'h04030201);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_ovf", {31'b0, overflow}, 32'd1);
      enable    = 1'b0;
      out_ready = 1'b1;
      @(negedge clk_50mhz);
      check("bp_accept_valid", {31'b0, out_valid}, 32'd0);
      enable = 1'b1;
      win(8'h09); win(8'h0a); win(8'h0b); win(8'h0c);
      check("bp_f3_out", out, 32'h0c0b0a09);
      check("bp_f3_valid", {31'b0, out_valid}, 32'd1);
      check("bp_ovf_sticky", {31'b0, overflow}, 32'd1);
      enable  = 1'b0;
      ovf_clr = 1'b1;
      @(negedge clk_50mhz);
      ovf_clr = 1'b0;
      check("bp_ovf_cleared", {31'b0, overflow}, 32'd0);
      check("bp_f3_accepted", {31'b0, out_valid}, 32'd0);

      // Accept in the same cycle the next frame completes
      out_ready = 1'b0;
      enable    = 1'b1;
      win(8'ha1); win(8'ha2); win(8'ha3); win(8'ha4);
      check("sim_f1_valid", {31'b0, out_valid}, 32'd1);
      win(8'hb1); win(8'hb2); win(8'hb3);
      sample_in = 8'hb4;
      repeat (DIV - 1) @(negedge clk_50mhz);
      check("sim_f1_still_out", out, 32'ha4a3a2a1);
      out_ready = 1'b1;
      @(negedge clk_50mhz);
      out_ready = 1'b0;
      check("sim_f2_out", out, 32'hb4b3b2b1);
      check("sim_f2_valid", {31'b0, out_valid}, 32'd1);
      check("sim_ovf", {31'b0, overflow}, 32'd0);
      enable    = 1'b0;
      out_ready = 1'b1;
      @(negedge clk_50mhz);
      check("sim_accept_valid", {31'b0, out_valid}, 32'd0);

      // Enable dropped mid-frame discards the partial frame
      enable = 1'b1;
      win(8'hc1); win(8'hc2);
      enable = 1'b0;
      repeat (3) @(negedge clk_50mhz);
      check("en_no_frame", {31'b0, out_valid}, 32'd0);
      enable = 1'b1;
      win(8'hd1); win(8'hd2); win(8'hd3);
      sample_in = 8'hd4;
      repeat (DIV - 1) @(negedge clk_50mhz);
      check("en_pre_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk_50mhz);
      check("en_out", out, 32'hd4d3d2d1);
      check("en_valid", {31'b0, out_valid}, 32'd1);
      enable = 1'b0;
      @(negedge clk_50mhz);

      // Drop coinciding with ovf_clr keeps overflow set
      out_ready = 1'b0;
      enable    = 1'b1;
      win(8'he1); win(8'he2); win(8'he3); win(8'he4);
      check("oc_e_out", out, 32'he4e3e2e1);
      win(8'hf1); win(8'hf2); win(8'hf3);
      sample_in = 8'hf4;
      repeat (DIV - 1) @(negedge clk_50mhz);
      ovf_clr = 1'b1;
      @(negedge clk_50mhz);
      check("oc_drop_wins", {31'b0, overflow}, 32'd1);
      check("oc_hold_out", out, 32'he4e3e2e1);
      enable = 1'b0;
      @(negedge clk_50mhz);
      ovf_clr = 1'b0;
      check("oc_clear_alone", {31'b0, overflow}, 32'd0);
      check("oc_still_valid", {31'b0, out_valid}, 32'd1);

      // Asynchronous reset while a frame is pending and overflow is set
      enable = 1'b1;
      win(8'h91); win(8'h92); win(8'h93); win(8'h94);
      check("ar_pre_valid", {31'b0, out_valid}, 32'd1);
      check("ar_pre_ovf", {31'b0, overflow}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_out", out, 32'h0);
      check("ar_valid", {31'b0, out_valid}, 32'd0);
      check("ar_ovf", {31'b0, overflow}, 32'd0);
      @(negedge clk_50mhz);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      win(8'h8d); win(8'h7c); win(8'h6b);
      check("ar_resume_pre", {31'b0, out_valid}, 32'd0);
      win(8'h5a);
      check("ar_resume_out", out, 32'h5a6b7c8d);
      check("ar_resume_valid", {31'b0, out_valid}, 32'd1);
      check("ar_resume_ovf", {31'b0, overflow}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
